// File: rtl/arb_pkg.sv
// Shared helpers for the matrix priority controller.
//   - arb_reset_bit : one element of the reset priority matrix
//                     (index 0 highest priority)
//   - arb_popcount  : number of set bits in a requester vector
//   - arb_is_onehot : exactly one bit set
// Requester vectors are zero-extended to ARB_MAX_W bits before they are
// passed to the vector helpers.
package arb_pkg;

    localparam int ARB_MAX_W = 32;

    typedef logic [ARB_MAX_W-1:0] arb_vec_t;

    // Matrix update selected for the current cycle.
    typedef enum logic [1:0] {
        UPD_NONE = 2'd0,
        UPD_LRU  = 2'd1,
        UPD_ERR  = 2'd2,
        UPD_INIT = 2'd3
    } arb_upd_e;

    // Reset matrix element m[row][col]: a requester yields to every lower index.
    function automatic logic arb_reset_bit(input int row, input int col);
        return (col < row);
    endfunction

    function automatic logic [5:0] arb_popcount(input arb_vec_t v);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int k = 0; k < ARB_MAX_W; k++) begin
            cnt = cnt + {5'd0, v[k]};
        end
        return cnt;
    endfunction

    function automatic logic arb_is_onehot(input arb_vec_t v);
        return (arb_popcount(v) == 6'd1);
    endfunction

endpackage

// File: rtl/arb_age_cnt.sv
// Per-requester starvation age counter.
// Counts cycles in which the requester is valid but not granted, saturating
// at LIMIT so that hit_o stays asserted until the requester is served or
// withdraws its request.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   vld_i  requester valid
//   rdy_i  requester granted
//   hit_o  counter has reached LIMIT
module arb_age_cnt #(
    parameter int AGE_W = 4,
    parameter int LIMIT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic vld_i,
    input  logic rdy_i,
    output logic hit_o
);

    localparam logic [AGE_W-1:0] LIMIT_C = AGE_W'(LIMIT);

    logic [AGE_W-1:0] cnt_q;
    logic [AGE_W-1:0] cnt_d;

    // Next age: grow while waiting, hold at the limit, clear otherwise.
    always_comb begin
        cnt_d = '0;
        if (vld_i && !rdy_i) begin
            if (cnt_q == LIMIT_C) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + AGE_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Age register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/arb_matrix_pri_ctrl.sv
// Matrix (LRU) priority controller for a downstream arbiter.
// Row i bit j of the matrix set means requester i yields to requester j.
// A completed packet (one-hot handshake on its last beat) moves the granted
// requester to lowest priority. Multi-hot handshakes are flagged on grant_err.
// Optional feature macro: ARB_MATRIX_AGE_EN -- per-requester starvation
// counters force a starving requester to top priority on the output only.
// Ports:
//   clk        clock (rising edge)
//   rst        synchronous active-high reset
//   v_vld_s    request vector
//   v_rdy_s    grant vector from the downstream arbiter
//   v_last_s   per-requester last-beat flag
//   pri_init   soft re-initialisation of the matrix
//   vv_matrix  priority matrix [row][col]
//   grant_err  one-cycle pulse after a multi-hot handshake
//   age_hit    requester currently forced to top priority (zero if none)
module arb_matrix_pri_ctrl
    import arb_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int AGE_W     = 4,
    parameter int AGE_LIMIT = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             v_vld_s,
    input  logic [WIDTH-1:0]             v_rdy_s,
    input  logic [WIDTH-1:0]             v_last_s,
    input  logic                         pri_init,
    output logic [WIDTH-1:0][WIDTH-1:0]  vv_matrix,
    output logic                         grant_err,
    output logic [WIDTH-1:0]             age_hit
);

    if ((WIDTH < 2) || (WIDTH > ARB_MAX_W) || (AGE_W < 1) ||
        (AGE_LIMIT >= (1 << AGE_W))) begin : g_illegal_cfg
        $error("arb_matrix_pri_ctrl: illegal parameter combination");
    end

    logic [WIDTH-1:0][WIDTH-1:0] mat_q;
    logic [WIDTH-1:0][WIDTH-1:0] mat_d;
    logic [WIDTH-1:0][WIDTH-1:0] rst_mat_s;
    logic                        grant_err_q;
    logic                        grant_err_d;
    logic [WIDTH-1:0]            hs_s;
    arb_vec_t                    hs_ext_s;
    logic [5:0]                  hs_cnt_s;
    logic                        hs_last_s;
    arb_upd_e                    upd_s;
    logic [WIDTH-1:0]            age_hit_s;

    // Constant reset matrix, shared by rst and pri_init.
    always_comb begin
        rst_mat_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                rst_mat_s[i][j] = arb_reset_bit(i, j);
            end
        end
    end

    // Handshake decode and update selection; pri_init beats everything.
    always_comb begin
        hs_s               = v_vld_s & v_rdy_s;
        hs_ext_s           = '0;
        hs_ext_s[WIDTH-1:0] = hs_s;
        hs_cnt_s           = arb_popcount(hs_ext_s);
        // With a one-hot handshake this is exactly v_last_s of the winner.
        hs_last_s          = |(hs_s & v_last_s);
        grant_err_d        = (hs_cnt_s > 6'd1);
        upd_s              = UPD_NONE;
        if (pri_init) begin
            upd_s = UPD_INIT;
        end else if (arb_is_onehot(hs_ext_s) && hs_last_s) begin
            upd_s = UPD_LRU;
        end else if (grant_err_d) begin
            upd_s = UPD_ERR;
        end else begin
            upd_s = UPD_NONE;
        end
    end

    // Next matrix state.
    always_comb begin
        mat_d = mat_q;
        case (upd_s)
            UPD_INIT: mat_d = rst_mat_s;
            UPD_LRU: begin
                // Winner row yields to all others; winner column cleared so
                // every other requester now beats it.
                for (int i = 0; i < WIDTH; i++) begin
                    for (int j = 0; j < WIDTH; j++) begin
                        if (hs_s[i]) begin
                            mat_d[i][j] = (i != j);
                        end else begin
                            mat_d[i][j] = mat_q[i][j] & ~hs_s[j];
                        end
                    end
                end
            end
            UPD_ERR:  mat_d = mat_q;
            UPD_NONE: mat_d = mat_q;
            default:  mat_d = mat_q;
        endcase
    end

    // Matrix and error-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mat_q       <= rst_mat_s;
            grant_err_q <= 1'b0;
        end else begin
            mat_q       <= mat_d;
            grant_err_q <= grant_err_d;
        end
    end

    assign grant_err = grant_err_q;
    assign age_hit   = age_hit_s;

`ifdef ARB_MATRIX_AGE_EN
    logic [WIDTH-1:0] age_at_lim_s;

    for (genvar g = 0; g < WIDTH; g++) begin : g_age
        arb_age_cnt #(
            .AGE_W (AGE_W),
            .LIMIT (AGE_LIMIT)
        ) u_age_cnt (
            .clk_i (clk),
            .rst_i (rst),
            .vld_i (v_vld_s[g]),
            .rdy_i (v_rdy_s[g]),
            .hit_o (age_at_lim_s[g])
        );
    end

    // Lowest starving index only; two's-complement trick isolates it.
    always_comb begin
        age_hit_s = age_at_lim_s & (~age_at_lim_s + {{(WIDTH-1){1'b0}}, 1'b1});
    end

    // Output view: starving requester yields to nobody and beats everybody.
    always_comb begin
        vv_matrix = mat_q;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (i == j) begin
                    vv_matrix[i][j] = 1'b0;
                end else if (age_hit_s[i]) begin
                    vv_matrix[i][j] = 1'b0;
                end else if (age_hit_s[j]) begin
                    vv_matrix[i][j] = 1'b1;
                end else begin
                    vv_matrix[i][j] = mat_q[i][j];
                end
            end
        end
    end
`else
    // Feature disabled: no aging, stored matrix shown as is.
    always_comb begin
        age_hit_s = '0;
        vv_matrix = mat_q;
    end
`endif

endmodule

// File: tb/tb_arb_matrix_pri_ctrl.sv
// Directed bench for arb_matrix_pri_ctrl (WIDTH=4, AGE_LIMIT=3).
// Matrix values are compared packed as {row3,row2,row1,row0}, bit 0 right.
module tb_arb_matrix_pri_ctrl;

    logic             clk;
    logic             rst;
    logic [3:0]       v_vld_s;
    logic [3:0]       v_rdy_s;
    logic [3:0]       v_last_s;
    logic             pri_init;
    logic [3:0][3:0]  vv_matrix;
    logic             grant_err;
    logic [3:0]       age_hit;

    int n_vec;
    int n_miss;

    arb_matrix_pri_ctrl #(
        .WIDTH     (4),
        .AGE_W     (4),
        .AGE_LIMIT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .v_vld_s   (v_vld_s),
        .v_rdy_s   (v_rdy_s),
        .v_last_s  (v_last_s),
        .pri_init  (pri_init),
        .vv_matrix (vv_matrix),
        .grant_err (grant_err),
        .age_hit   (age_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the clock edge.
    task automatic cyc(input logic [3:0] vld, input logic [3:0] rdy,
                       input logic [3:0] last, input logic init);
        v_vld_s  = vld;
        v_rdy_s  = rdy;
        v_last_s = last;
        pri_init = init;
        @(posedge clk);
        #1;
    endtask

    // Requester that wins among req: it yields to no other requester.
    function automatic int winner(input logic [15:0] m, input logic [3:0] req);
        logic [3:0] row;
        for (int i = 0; i < 4; i++) begin
            row = m[i*4 +: 4];
            if (req[i] && ((row & req) == 4'b0000)) return i;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
        cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        v_vld_s  = 4'b0000;
        v_rdy_s  = 4'b0000;
        v_last_s = 4'b0000;
        pri_init = 1'b0;
        do_reset();

        // Reset state: rows 0000,0001,0011,0111.
        check_vec("rst_matrix", 32'(vv_matrix), 32'h0000_7310);
        check_vec("rst_gerr",   32'(grant_err), 32'h0);
        check_vec("rst_age",    32'(age_hit),   32'h0);

        // Request without grant: no handshake, no change.
        cyc(4'b1000, 4'b0000, 4'b1000, 1'b0);
        check_vec("no_hs", 32'(vv_matrix), 32'h0000_7310);

        // Single-beat packet from requester 0.
        cyc(4'b1111, 4'b0001, 4'b0001, 1'b0);
        check_vec("lru0_matrix", 32'(vv_matrix), 32'h0000_620E);
        check_vec("lru0_row0",   32'(vv_matrix[0]), 32'h0000_000E);
        check_vec("lru0_col0",   32'({vv_matrix[3][0], vv_matrix[2][0], vv_matrix[1][0]}), 32'h0);
        check_vec("lru0_winner", 32'(winner(16'(vv_matrix), 4'b1111)), 32'd1);
        check_vec("lru0_gerr",   32'(grant_err), 32'h0);

        cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
        check_vec("idle_hold", 32'(vv_matrix), 32'h0000_620E);

        // Three-beat packet from requester 2, last only on beat 3.
        cyc(4'b0100, 4'b0100, 4'b0000, 1'b0);
        check_vec("pkt_beat1", 32'(vv_matrix), 32'h0000_620E);
        cyc(4'b0100, 4'b0100, 4'b0000, 1'b0);
        check_vec("pkt_beat2", 32'(vv_matrix), 32'h0000_620E);
        cyc(4'b0100, 4'b0100, 4'b0100, 1'b0);
        check_vec("pkt_beat3", 32'(vv_matrix), 32'h0000_2B0A);

        // Multi-hot handshake: matrix held, one-cycle error pulse.
        cyc(4'b0110, 4'b0110, 4'b0110, 1'b0);
        check_vec("mh_matrix", 32'(vv_matrix), 32'h0000_2B0A);
        check_vec("mh_gerr1",  32'(grant_err), 32'h1);
        cyc(4'b0000, 4'b0000, 4'b0000, 1'b0);
        check_vec("mh_gerr2",  32'(grant_err), 32'h0);
        check_vec("mh_hold",   32'(vv_matrix), 32'h0000_2B0A);

        // pri_init wins over a simultaneous last-beat handshake.
        cyc(4'b1000, 4'b1000, 4'b1000, 1'b1);
        check_vec("init_matrix", 32'(vv_matrix), 32'h0000_7310);

        // One-hot handshake whose last flag belongs to another requester.
        cyc(4'b1000, 4'b1000, 4'b0100, 1'b0);
        check_vec("wrong_last", 32'(vv_matrix), 32'h0000_7310);

        // Requester 2 completes from the reset matrix.
        cyc(4'b0100, 4'b0100, 4'b0100, 1'b0);
        check_vec("lru2_matrix", 32'(vv_matrix), 32'h0000_3B10);

        // Starvation of requester 3.
        do_reset();
        cyc(4'b1000, 4'b0000, 4'b0000, 1'b0);
        cyc(4'b1000, 4'b0000, 4'b0000, 1'b0);
        check_vec("age_wait2", 32'(age_hit), 32'h0);
        cyc(4'b1000, 4'b0000, 4'b0000, 1'b0);
`ifdef ARB_MATRIX_AGE_EN
        check_vec("age_hit",    32'(age_hit),      32'h8);
        check_vec("age_row3",   32'(vv_matrix[3]), 32'h0);
        check_vec("age_matrix", 32'(vv_matrix),    32'h0000_0B98);
        cyc(4'b1000, 4'b1000, 4'b0000, 1'b0);
        check_vec("age_clear",  32'(age_hit),      32'h0);
        check_vec("age_unmod",  32'(vv_matrix),    32'h0000_7310);
`else
        check_vec("age_off_hit",    32'(age_hit),   32'h0);
        check_vec("age_off_matrix", 32'(vv_matrix), 32'h0000_7310);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/arb_matrix_pri_ctrl.md
ARB_MATRIX_PRI_CTRL -- requirements
Module: arb_matrix_pri_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of requesters; legal range 2..32.
REQ-002 SHALL have parameter AGE_W, default 4: width of each age counter; used only with ARB_MATRIX_AGE_EN.
REQ-003 SHALL have parameter AGE_LIMIT, default 15: starvation threshold in cycles; must be < 2^AGE_W.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port v_vld_s  in  WIDTH  request vector, as seen by the downstream arbiter.
REQ-007 SHALL have port v_rdy_s  in  WIDTH  grant vector returned by the downstream arbiter.
REQ-008 SHALL have port v_last_s  in  WIDTH  per-requester last-beat flag; priority rotates only on the last beat.
REQ-009 SHALL have port pri_init  in  1  single-cycle soft re-initialisation of the matrix.
REQ-010 SHALL have port vv_matrix  out  WIDTH x WIDTH  priority matrix; row i bit j = 1 means requester i yields to j.
REQ-011 SHALL have port grant_err  out  1  registered one-cycle pulse flagging a non-one-hot handshake.
REQ-012 SHALL have port age_hit  out  WIDTH  one-hot (or zero) requester currently forced to top priority.

Function
REQ-013 SHALL define the handshake as hs = v_vld_s & v_rdy_s, evaluated every cycle.
REQ-014 SHALL keep the matrix register antisymmetric with a zero diagonal: for all i != j, exactly one of m[i][j], m[j][i] is 1.
REQ-015 SHALL, when hs is one-hot with index g and v_last_s[g] = 1, set row g to all ones except bit g and clear column g, effective next cycle (LRU update).
REQ-016 SHALL leave the matrix unchanged on a one-hot hs with v_last_s[g] = 0, so multi-beat packets keep their grant.
REQ-017 SHALL, when hs has two or more bits set, leave the matrix unchanged and pulse grant_err high the following cycle.
REQ-018 SHALL give pri_init precedence over any simultaneous hs update, loading the reset matrix next cycle.
REQ-019 SHALL drive vv_matrix combinationally from registered state only; no input-to-output combinational path.
REQ-020 SHALL produce no more than one matrix update per cycle, with one-cycle latency from hs to the new vv_matrix.

Reset
REQ-021 SHALL on rst load m[i][j] = 1 iff j < i, so index 0 has the highest priority.
REQ-022 SHALL on rst clear grant_err, age_hit and all age counters; reset mid-packet discards packet lock state.

Configuration
REQ-023 SHALL, with ARB_MATRIX_AGE_EN defined, keep one saturating AGE_W counter per requester that increments while v_vld_s[i] & ~v_rdy_s[i] and clears on v_rdy_s[i] or ~v_vld_s[i].
REQ-024 SHALL, with ARB_MATRIX_AGE_EN defined, set age_hit to the lowest index whose counter equals AGE_LIMIT, and override vv_matrix row = 0 and column = 1 (off-diagonal) for that index, without modifying the stored matrix.
REQ-025 SHALL, without ARB_MATRIX_AGE_EN, contain no age counters, tie age_hit to 0, and output the stored matrix unmodified.

Structure
REQ-026 SHALL place the reset-matrix function and one-hot/popcount helpers in shared package arb_pkg.
REQ-027 SHALL implement age tracking as sub-module arb_age_cnt, instantiated per requester only under ARB_MATRIX_AGE_EN.

Verification
REQ-028 SHALL check, with WIDTH=4 after rst, that vv_matrix rows are {0000, 0001, 0011, 0111} (row 0..3, bit 0 at the right).
REQ-029 SHALL check that hs=0001 with last=0001 yields row0=1110 and column 0 cleared the next cycle, and that requester 1 now wins ties.
REQ-030 SHALL check that hs=0100 held for 3 beats with last only on beat 3 leaves the matrix unchanged until the cycle after beat 3.
REQ-031 SHALL check that hs=0110 leaves the matrix unchanged and pulses grant_err for exactly one cycle.
REQ-032 SHALL check that pri_init and hs=1000/last=1000 in the same cycle give the reset matrix next cycle.
REQ-033 SHALL check, with AGE_EN and AGE_LIMIT=3, that v_vld_s[3] held 3 cycles without grant gives age_hit=1000 with row3=0000, and that the grant clears it next cycle.
